// File: rtl/jam_pkg.sv
// ============================================================================
// Module      : jam_pkg
// Description : Shared constants for the JAM cost-table loader. It holds the
//               table geometry, the result widths and the loader state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jam_pkg;

   // Cost word width. It matches the JAM Cost input.
   localparam int COST_W    = 7;
   // Workers per row. The table is N_WORK x N_WORK.
   localparam int N_WORK    = 8;
   localparam int TBL_DEPTH = N_WORK * N_WORK;
   localparam int ADDR_W    = 6;
   // Widths of the JAM result buses.
   localparam int MINCOST_W = 10;
   localparam int MATCH_W   = 4;

   // Loader state encoding.
   typedef logic [1:0] state_t;
   localparam logic [1:0] ST_LOAD = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;

   // Row-major table address. It is the concatenation of the worker and job indices.
   function automatic logic [ADDR_W-1:0] tbl_addr(input logic [2:0] w, input logic [2:0] j);
      return {w, j};
   endfunction

endpackage

`default_nettype wire

// File: rtl/jam_cost_ram.sv
// ============================================================================
// Module      : jam_cost_ram
// Description : Cost table storage. It has one synchronous write port and
//               one asynchronous read port. The contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jam_cost_ram #(
   parameter int COST_W = 7,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              CLK,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [COST_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [COST_W-1:0] rdata
);

   logic [COST_W-1:0] r_mem [0:DEPTH-1];

   // Write the streamed word into its table slot.
   always_ff @(posedge CLK) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   // Zero-latency read. JAM sums Cost in the same cycle it presents W and J.
   assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/jam_cost_loader.sv
// ============================================================================
// Module      : jam_cost_loader
// Description : Upstream stage of the JAM assignment engine. It loads an 8x8
//               cost table from a stream and holds JAM in reset until the table
//               is complete. It then serves JAM's (W,J) lookups, captures the
//               result on jam_valid and watchdogs the run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jam_cost_loader #(
   parameter int COST_W  = jam_pkg::COST_W,
   parameter int TIMEOUT = 500000,
   parameter int TO_W    = 20
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [COST_W-1:0]            in_data,
   input  logic                         in_last,
   input  logic                         restart,
   input  logic [2:0]                   W,
   input  logic [2:0]                   J,
   output logic [COST_W-1:0]            Cost,
   output logic                         jam_rst,
   input  logic                         jam_valid,
   input  logic [jam_pkg::MINCOST_W-1:0] jam_mincost,
   input  logic [jam_pkg::MATCH_W-1:0]   jam_match,
   output logic [jam_pkg::MINCOST_W-1:0] res_mincost,
   output logic [jam_pkg::MATCH_W-1:0]   res_match,
   output logic                         done,
   output logic                         err
);

   import jam_pkg::*;

   // The watchdog fires when its count reaches this value. RUN then lasts exactly TIMEOUT cycles.
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] WCNT_END = ADDR_W'(TBL_DEPTH - 1);

   state_t                 r_state;
   logic [ADDR_W-1:0]      r_wcnt;
   logic [TO_W-1:0]        r_wdog;
   logic                   r_jam_rst;
   logic [MINCOST_W-1:0]   r_res_mincost;
   logic [MATCH_W-1:0]     r_res_match;

   logic                   w_xfer;
   logic                   w_wcnt_end;
   logic                   w_we;
   logic                   w_timeout;
   logic [COST_W-1:0]      w_rdata;

   assign w_xfer     = in_valid & in_ready;
   assign w_wcnt_end = (r_wcnt == WCNT_END);
   // An early in_last discards its word. A missing last on word 63 still writes, then errors.
   assign w_we       = w_xfer & (w_wcnt_end | ~in_last);
   assign w_timeout  = (r_wdog == TO_LAST);

   jam_cost_ram #(
      .COST_W (COST_W),
      .DEPTH  (TBL_DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .CLK   (CLK),
      .we    (w_we),
      .waddr (r_wcnt),
      .wdata (in_data),
      .raddr (tbl_addr(W, J)),
      .rdata (w_rdata)
   );

   // Loader FSM with the word counter, the watchdog and the JAM reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state   <= ST_LOAD;
         r_wcnt    <= '0;
         r_wdog    <= '0;
         r_jam_rst <= 1'b1;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (w_xfer) begin
                  if (in_last && w_wcnt_end) begin
                     r_state   <= ST_RUN;
                     r_wdog    <= '0;
                     r_jam_rst <= 1'b0;
                  end else if (in_last || w_wcnt_end) begin
                     // The end of the stream came early or the last marker is missing. The counter never wraps.
                     r_state <= ST_ERR;
                  end else begin
                     r_wcnt <= r_wcnt + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (jam_valid) begin
                  r_state   <= ST_DONE;
                  r_jam_rst <= 1'b1;
               end else if (w_timeout) begin
                  r_state   <= ST_ERR;
                  r_jam_rst <= 1'b1;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            default: begin
               // DONE and ERR wait for restart. JAM stays in reset.
               if (restart) begin
                  r_state <= ST_LOAD;
                  r_wcnt  <= '0;
                  r_wdog  <= '0;
               end
            end
         endcase
      end
   end

   // Capture the JAM result on a Valid pulse in RUN. Otherwise hold it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_res_mincost <= '0;
         r_res_match   <= '0;
      end else if ((r_state == ST_RUN) && jam_valid) begin
         r_res_mincost <= jam_mincost;
         r_res_match   <= jam_match;
      end
   end

   assign in_ready    = (r_state == ST_LOAD);
   assign done        = (r_state == ST_DONE);
   assign err         = (r_state == ST_ERR);
   assign jam_rst     = r_jam_rst;
   assign res_mincost = r_res_mincost;
   assign res_match   = r_res_match;
   // Cost reads as zero outside RUN, so JAM never sees a partially loaded table.
   assign Cost        = (r_state == ST_RUN) ? w_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_jam_cost_loader.sv
// ============================================================================
// Module      : tb_jam_cost_loader
// Description : Self-checking bench for jam_cost_loader. It uses directed
//               vectors and hand-computed expectations. A second instance with
//               a short watchdog exercises the timeout paths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_jam_cost_loader;

   localparam int CW = 7;

   logic          CLK;
   logic          RST;
   logic          in_valid;
   logic [CW-1:0] in_data;
   logic          in_last;
   logic          restart;
   logic [2:0]    W;
   logic [2:0]    J;
   logic          jam_valid;
   logic [9:0]    jam_mincost;
   logic [3:0]    jam_match;

   logic          in_ready,  in_ready_to;
   logic [CW-1:0] Cost,      Cost_to;
   logic          jam_rst,   jam_rst_to;
   logic [9:0]    res_mincost, res_mincost_to;
   logic [3:0]    res_match, res_match_to;
   logic          done,      done_to;
   logic          err,       err_to;

   int n_checks;
   int n_fail;

   jam_cost_loader dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .restart(restart), .W(W), .J(J), .Cost(Cost), .jam_rst(jam_rst),
      .jam_valid(jam_valid), .jam_mincost(jam_mincost), .jam_match(jam_match),
      .res_mincost(res_mincost), .res_match(res_match), .done(done), .err(err)
   );

   jam_cost_loader #(.TIMEOUT(100), .TO_W(20)) dut_to (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_to), .in_data(in_data),
      .in_last(in_last), .restart(restart), .W(W), .J(J), .Cost(Cost_to), .jam_rst(jam_rst_to),
      .jam_valid(jam_valid), .jam_mincost(jam_mincost), .jam_match(jam_match),
      .res_mincost(res_mincost_to), .res_match(res_match_to), .done(done_to), .err(err_to)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [2:0]    w;
      logic [2:0]    j;
      logic [CW-1:0] cost;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Table patterns. Mode 0: (W+J)%8. Mode 1: 1 on the diagonal and 50 elsewhere. Mode 2: a scrambled pattern.
   function automatic logic [CW-1:0] cost_of(input int mode, input int idx);
      int w, j;
      w = idx / 8;
      j = idx % 8;
      case (mode)
         0:       return CW'((w + j) % 8);
         1:       return (w == j) ? CW'(1) : CW'(50);
         default: return CW'((idx * 37 + 11) % 128);
      endcase
   endfunction

   task automatic send_word(input logic [CW-1:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Send count words starting at first. in_last marks last_idx (-1 means never). Gaps are random, up to max_gap idle cycles.
   task automatic load_words(input int mode, input int max_gap, input int first, input int count,
                             input int last_idx);
      for (int i = first; i < first + count; i++) begin
         if (max_gap > 0) repeat ($urandom_range(0, max_gap)) step();
         send_word(cost_of(mode, i), (i == last_idx));
      end
   endtask

   task automatic check_table(input int mode, input string tag);
      for (int i = 0; i < 64; i++) begin
         W = 3'(i / 8);
         J = 3'(i % 8);
         #1;
         chk(tag, Cost, cost_of(mode, i));
      end
   endtask

   // Act as JAM using the identity assignment: sum Cost on the diagonal, then pulse Valid with that sum.
   task automatic jam_diag_run(output int sum);
      sum = 0;
      for (int k = 0; k < 8; k++) begin
         W = 3'(k);
         J = 3'(k);
         #1;
         sum += int'(Cost);
      end
      step();
      jam_valid   = 1'b1;
      jam_mincost = 10'(sum);
      jam_match   = 4'd1;
      step();
      jam_valid   = 1'b0;
   endtask

   task automatic jam_pulse(input int mc, input int mt);
      jam_valid   = 1'b1;
      jam_mincost = 10'(mc);
      jam_match   = 4'(mt);
      step();
      jam_valid   = 1'b0;
   endtask

   task automatic do_restart();
      restart = 1'b1;
      step();
      restart = 1'b0;
   endtask

   initial begin
      vec_t vecs [8];
      int   sum;

      n_checks    = 0;
      n_fail      = 0;
      RST         = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;
      in_last     = 1'b0;
      restart     = 1'b0;
      W           = 3'd3;
      J           = 3'd5;
      jam_valid   = 1'b0;
      jam_mincost = '0;
      jam_match   = '0;

      vecs[0] = '{3'd0, 3'd0, 7'd0};
      vecs[1] = '{3'd3, 3'd5, 7'd0};
      vecs[2] = '{3'd7, 3'd7, 7'd6};
      vecs[3] = '{3'd1, 3'd2, 7'd3};
      vecs[4] = '{3'd7, 3'd0, 7'd7};
      vecs[5] = '{3'd4, 3'd6, 7'd2};
      vecs[6] = '{3'd2, 3'd7, 7'd1};
      vecs[7] = '{3'd6, 3'd5, 7'd3};

      // Reset state
      step();
      step();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_jam_rst", jam_rst, 1);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_res_mincost", res_mincost, 0);
      chk("rst_res_match", res_match, 0);
      chk("rst_cost", Cost, 0);
      RST = 1'b0;
      step();

      // Scenario 1: (W+J)%8 table. The last marker goes on word 63.
      load_words(0, 0, 0, 63, 63);
      chk("s1_pre_last_ready", in_ready, 1);
      chk("s1_pre_last_jam_rst", jam_rst, 1);
      chk("s1_cost_in_load", Cost, 0);
      send_word(cost_of(0, 63), 1'b1);
      chk("s1_ready_dropped", in_ready, 0);
      chk("s1_jam_rst_low", jam_rst, 0);
      for (int v = 0; v < 8; v++) begin
         W = vecs[v].w;
         J = vecs[v].j;
         #1;
         chk("s1_cost_vec", Cost, vecs[v].cost);
      end
      check_table(0, "s1_cost_all");
      // In RUN, stream words and restart must be ignored.
      in_valid = 1'b1; in_data = 7'd99; in_last = 1'b1; restart = 1'b1;
      step();
      in_valid = 1'b0; in_last = 1'b0; restart = 1'b0;
      chk("s1_run_ready", in_ready, 0);
      chk("s1_run_err", err, 0);
      chk("s1_run_jam_rst", jam_rst, 0);
      W = 3'd0; J = 3'd0; #1;
      chk("s1_run_cost00", Cost, 0);
      jam_pulse(5, 2);
      chk("s1_done", done, 1);
      chk("s1_res_mincost", res_mincost, 5);
      chk("s1_res_match", res_match, 2);
      // jam_valid outside RUN must be ignored.
      jam_pulse(777, 9);
      chk("s1_ignored_mincost", res_mincost, 5);
      chk("s1_ignored_match", res_match, 2);

      // Scenario 2: diagonal table run
      do_restart();
      chk("s2_restart_ready", in_ready, 1);
      chk("s2_restart_done", done, 0);
      load_words(1, 0, 0, 64, 63);
      W = 3'd2; J = 3'd5; #1;
      chk("s2_cost_offdiag", Cost, 50);
      jam_diag_run(sum);
      chk("s2_diag_sum", sum, 8);
      chk("s2_res_mincost", res_mincost, 8);
      chk("s2_res_match", res_match, 1);
      chk("s2_done", done, 1);
      chk("s2_jam_rst", jam_rst, 1);
      chk("s2_cost_after", Cost, 0);

      // Scenario 3: early end on word 10
      do_restart();
      load_words(0, 0, 0, 10, -1);
      chk("s3_pre_err", err, 0);
      send_word(cost_of(0, 10), 1'b1);
      chk("s3_err", err, 1);
      chk("s3_jam_rst", jam_rst, 1);
      chk("s3_ready", in_ready, 0);
      chk("s3_res_held", res_mincost, 8);
      do_restart();
      chk("s3_restart_err", err, 0);
      chk("s3_restart_ready", in_ready, 1);

      // Scenario 4: missing last. Then a gapped load whose table must read back intact.
      load_words(2, 0, 0, 63, -1);
      chk("s4_pre_err", err, 0);
      chk("s4_pre_ready", in_ready, 1);
      send_word(cost_of(2, 63), 1'b0);
      chk("s4_missing_last_err", err, 1);
      chk("s4_missing_last_jam_rst", jam_rst, 1);
      do_restart();
      load_words(2, 3, 0, 64, 63);
      chk("s4_gap_run", jam_rst, 0);
      check_table(2, "s4_gap_table");
      jam_pulse(300, 9);
      chk("s4_res_mincost", res_mincost, 300);
      chk("s4_res_match", res_match, 9);

      // Scenario 5: watchdog on the TIMEOUT=100 instance
      RST = 1'b1;
      step();
      RST = 1'b0;
      step();
      load_words(0, 0, 0, 64, 63);
      repeat (99) step();
      chk("s5_to_err_at_99", err_to, 0);
      chk("s5_to_jam_rst_at_99", jam_rst_to, 0);
      step();
      chk("s5_to_err_at_100", err_to, 1);
      chk("s5_to_jam_rst_at_100", jam_rst_to, 1);
      chk("s5_main_still_run", jam_rst, 0);
      chk("s5_main_no_err", err, 0);
      jam_pulse(1, 1);
      chk("s5_main_done", done, 1);
      do_restart();
      load_words(0, 0, 0, 64, 63);
      repeat (99) step();
      jam_pulse(123, 3);
      chk("s5_same_cycle_done", done_to, 1);
      chk("s5_same_cycle_err", err_to, 0);
      chk("s5_same_cycle_mincost", res_mincost_to, 123);
      chk("s5_same_cycle_match", res_match_to, 3);

      // Scenario 6: asynchronous reset in the middle of RUN
      do_restart();
      load_words(1, 0, 0, 64, 63);
      repeat (500) step();
      chk("s6_in_run", jam_rst, 0);
      W = 3'd4; J = 3'd4; #1;
      chk("s6_cost_pre_rst", Cost, 1);
      #2;
      RST = 1'b1;
      #1;
      chk("s6_async_jam_rst", jam_rst, 1);
      chk("s6_async_ready", in_ready, 1);
      chk("s6_async_done", done, 0);
      chk("s6_async_err", err, 0);
      chk("s6_async_mincost", res_mincost, 0);
      chk("s6_async_match", res_match, 0);
      chk("s6_async_cost", Cost, 0);
      step();
      RST = 1'b0;
      step();
      load_words(1, 0, 0, 64, 63);
      jam_diag_run(sum);
      chk("s6_rerun_sum", sum, 8);
      chk("s6_rerun_mincost", res_mincost, 8);
      chk("s6_rerun_match", res_match, 1);
      chk("s6_rerun_done", done, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
